// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one request at a time against a single-cycle-read RAM,
// with sub-word stores done as read-modify-write and load results extended to a full word.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_lsu_req_valid,
  output logic                  o_lsu_req_ready,
  input  logic                  i_lsu_req_we,
  input  logic [ADDR_WIDTH-1:0] i_lsu_req_addr,
  input  logic [1:0]            i_lsu_req_size,
  input  logic                  i_lsu_req_unsigned,
  input  logic [DATA_WIDTH-1:0] i_lsu_req_wdata,
  output logic                  o_lsu_resp_valid,
  input  logic                  i_lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] o_lsu_resp_rdata,
  output logic                  o_lsu_resp_err,
  output logic                  o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  we_q;
  logic                  uns_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;

  logic                  accept;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] load_data;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;

  assign accept    = i_lsu_req_valid && o_lsu_req_ready;
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    case (i_lsu_req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = i_lsu_req_addr[0];
      2'd2:    req_err = (i_lsu_req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= i_lsu_req_addr;
        size_q  <= i_lsu_req_size;
        we_q    <= i_lsu_req_we;
        uns_q   <= i_lsu_req_unsigned;
        wdata_q <= i_lsu_req_wdata;
        err_q   <= req_err;
      end
      if (state == RD) word_q <= i_ram_rd_data;
    end
  end

  // NOTE: defaults first in every combinational block so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                                 state_next = RESP;
          else if (i_lsu_req_we && i_lsu_req_size == 2'd2) state_next = WR;
          else                                         state_next = RD;
        end
      end
      RD:      state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    if (i_lsu_resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store merge: replace only the addressed lane of the word captured in RD.
  always_comb begin
    merged = word_q;
    case (size_q)
      2'd0:    merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'd1:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign sel_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
  assign sel_half = word_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'd0:    load_data = {{(DATA_WIDTH-8){sel_byte[7] & ~uns_q}}, sel_byte};
      2'd1:    load_data = {{(DATA_WIDTH-16){sel_half[15] & ~uns_q}}, sel_half};
      default: load_data = word_q;
    endcase
  end

  always_comb begin
    o_lsu_req_ready  = (state == IDLE) && !i_sys_rst;
    o_lsu_resp_valid = (state == RESP);
    o_lsu_resp_err   = (state == RESP) && err_q;
    o_lsu_resp_rdata = '0;
    o_ram_rd_en      = 1'b0;
    o_ram_rd_addr    = '0;
    o_ram_wr_en      = 1'b0;
    o_ram_wr_addr    = '0;
    o_ram_wr_data    = '0;
    case (state)
      RD: begin
        o_ram_rd_en   = 1'b1;
        o_ram_rd_addr = word_addr;
      end
      WR: begin
        o_ram_wr_en   = 1'b1;
        o_ram_wr_addr = word_addr;
        o_ram_wr_data = merged;
      end
      RESP:    if (!we_q && !err_q) o_lsu_resp_rdata = load_data;
      default: ;
    endcase
  end

endmodule
